ni_packet_tx: RTL and testbench

Network-interface transmit block that turns a whole packet from a core into the phit stream a router input port consumes. It emits a head flit carrying the destination, then payload flits, then a tail flit. Each flit is split into PHIT_PER_FLIT phits under a valid/ready handshake, with the flit type presented alongside every phit. It sits between a processing element and the local input port of its router, and is the transmit end of the router's phit/flit protocol.

---
 rtl/noc_pkg.sv | 30 +++
 rtl/flit_serializer.sv | 41 ++++
 rtl/ni_packet_tx.sv | 145 ++++++++++++++
 tb/tb_ni_packet_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, transmit FSM encoding and the flit type width
// used by both the NI transmit side and the router input-port control.
package noc_pkg;

  localparam int NOC_TYPE_W = 2;

  typedef enum logic [NOC_TYPE_W-1:0] {
    FLIT_NONE    = 2'd0,
    FLIT_HEAD    = 2'd1,
    FLIT_PAYLOAD = 2'd2,
    FLIT_TAIL    = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HEAD,
    TX_PAYLOAD,
    TX_TAIL
  } tx_state_e;

  function automatic flit_type_e flitTypeOf(input tx_state_e s);
    case (s)
      TX_HEAD:    return FLIT_HEAD;
      TX_PAYLOAD: return FLIT_PAYLOAD;
      TX_TAIL:    return FLIT_TAIL;
      default:    return FLIT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/flit_serializer.sv
// Phit selector for one flit: owns the phit counter (advances only on a handshake,
// wraps at the end of the flit) and muxes the current phit out of the flit word.
module flit_serializer
  import noc_pkg::*;
#(
  parameter int PHIT_WIDTH    = 32,
  parameter int PHIT_PER_FLIT = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                advance,
  input  logic [PHIT_WIDTH*PHIT_PER_FLIT-1:0] flitWord,
  output logic [PHIT_WIDTH-1:0]               phitOut,
  output logic                                lastPhit
);

  localparam int PCW = (PHIT_PER_FLIT > 1) ? $clog2(PHIT_PER_FLIT) : 1;

  logic [PCW-1:0] phitCnt;

  assign lastPhit = (phitCnt == PCW'(PHIT_PER_FLIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      phitCnt <= '0;
    end else if (advance) begin
      phitCnt <= lastPhit ? '0 : phitCnt + PCW'(1);
    end
  end

  // Least-significant phit of the flit goes out first.
  always_comb begin
    phitOut = '0;
    for (int p = 0; p < PHIT_PER_FLIT; p++) begin
      if (phitCnt == PCW'(p)) begin
        phitOut = flitWord[p*PHIT_WIDTH +: PHIT_WIDTH];
      end
    end
  end

endmodule

// File: rtl/ni_packet_tx.sv
// NI transmit: serialises an accepted packet into head/payload/tail flits of phits.
// Optional macro NI_TX_BACK2BACK_EN: accept the next packet on the final tail handshake (no bubble).
module ni_packet_tx
  import noc_pkg::*;
#(
  parameter int PHIT_WIDTH      = 32,
  parameter int PHIT_PER_FLIT   = 2,
  parameter int FLIT_PER_PACKET = 4,
  parameter int DEST_WIDTH      = 4,
  parameter int TYPE_WIDTH      = NOC_TYPE_W
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        pkt_valid,
  output logic                                                        pkt_ready,
  input  logic [DEST_WIDTH-1:0]                                       pkt_dest,
  input  logic [PHIT_WIDTH*PHIT_PER_FLIT*(FLIT_PER_PACKET-1)-1:0]     pkt_payload,
  output logic [PHIT_WIDTH-1:0]                                       phit_out,
  output logic [TYPE_WIDTH-1:0]                                       flit_type_out,
  output logic                                                        valid_out,
  input  logic                                                        ready_out,
  output logic                                                        pkt_done
);

  localparam int FLIT_W = PHIT_WIDTH * PHIT_PER_FLIT;
  localparam int PAY_W  = FLIT_W * (FLIT_PER_PACKET - 1);
  localparam int FCW    = $clog2(FLIT_PER_PACKET);

  tx_state_e             state, stateNext;
  logic [FCW-1:0]        flitCnt, flitCntNext;
  logic [DEST_WIDTH-1:0] destReg;
  logic [PAY_W-1:0]      payloadReg;
  logic [FLIT_W-1:0]     flitWord;
  logic [PHIT_WIDTH-1:0] phitSel;
  logic                  accept;
  logic                  handshake;
  logic                  lastPhit;
  logic                  flitDone;
  logic                  lastFlitDone;

  // valid_out comes straight from the state register so a ready that depends on valid cannot loop.
  assign valid_out    = (state != TX_IDLE);
  assign handshake    = valid_out & ready_out;
  assign flitDone     = handshake & lastPhit;
  assign lastFlitDone = flitDone & (state == TX_TAIL);
  assign pkt_done     = lastFlitDone;

`ifdef NI_TX_BACK2BACK_EN
  assign pkt_ready = ~rst & ((state == TX_IDLE) | lastFlitDone);
`else
  assign pkt_ready = ~rst & (state == TX_IDLE);
`endif

  assign accept = pkt_valid & pkt_ready;

  always_comb begin
    stateNext   = state;
    flitCntNext = flitCnt;
    case (state)
      TX_IDLE: begin
        if (accept) begin
          stateNext   = TX_HEAD;
          flitCntNext = '0;
        end
      end
      TX_HEAD: begin
        if (flitDone) begin
          flitCntNext = flitCnt + FCW'(1);
          stateNext   = (FLIT_PER_PACKET == 2) ? TX_TAIL : TX_PAYLOAD;
        end
      end
      TX_PAYLOAD: begin
        if (flitDone) begin
          flitCntNext = flitCnt + FCW'(1);
          if (flitCnt == FCW'(FLIT_PER_PACKET - 2)) begin
            stateNext = TX_TAIL;
          end
        end
      end
      TX_TAIL: begin
        if (flitDone) begin
          stateNext   = TX_IDLE;
          flitCntNext = '0;
`ifdef NI_TX_BACK2BACK_EN
          if (accept) begin
            stateNext = TX_HEAD;
          end
`endif
        end
      end
      default: begin
        stateNext   = TX_IDLE;
        flitCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      flitCnt <= '0;
    end else begin
      state   <= stateNext;
      flitCnt <= flitCntNext;
    end
  end

  // Packet capture: data registers carry no reset, they are qualified by state.
  always_ff @(posedge clk) begin
    if (accept) begin
      destReg    <= pkt_dest;
      payloadReg <= pkt_payload;
    end
  end

  // Head flit carries only the zero-extended destination; flit f>=1 maps to payload slot f-1.
  always_comb begin
    flitWord = '0;
    if (state == TX_HEAD) begin
      flitWord[DEST_WIDTH-1:0] = destReg;
    end else if (state != TX_IDLE) begin
      for (int f = 1; f < FLIT_PER_PACKET; f++) begin
        if (flitCnt == FCW'(f)) begin
          flitWord = payloadReg[(f-1)*FLIT_W +: FLIT_W];
        end
      end
    end
  end

  flit_serializer #(
    .PHIT_WIDTH    (PHIT_WIDTH),
    .PHIT_PER_FLIT (PHIT_PER_FLIT)
  ) uSer (
    .clk      (clk),
    .rst      (rst),
    .advance  (handshake),
    .flitWord (flitWord),
    .phitOut  (phitSel),
    .lastPhit (lastPhit)
  );

  assign phit_out      = valid_out ? phitSel : '0;
  assign flit_type_out = TYPE_WIDTH'(flitTypeOf(state));

endmodule

// File: tb/tb_ni_packet_tx.sv
// Bench for ni_packet_tx: a 4-flit and a 2-flit instance checked against a phit-queue model
// of each packet, with directed scenarios followed by randomized traffic and backpressure.
module tb_ni_packet_tx;

  localparam int PW  = 8;
  localparam int PPF = 2;
  localparam int FPP = 4;
  localparam int DW  = 4;
`ifdef NI_TX_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] phit;
    logic [1:0] typ;
    logic       last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        pktValid, pktReady, validOut, readyOut, pktDone;
  logic [3:0]  pktDest;
  logic [47:0] pktPayload;
  logic [7:0]  phitOut;
  logic [1:0]  flitType;

  logic        pktValid1, pktReady1, validOut1, readyOut1, pktDone1;
  logic [3:0]  pktDest1;
  logic [15:0] pktPayload1;
  logic [7:0]  phitOut1;
  logic [1:0]  flitType1;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  logic sValid, sDone, sAcc, sAcc1;
  logic [7:0] sPhit;
  logic [1:0] sType;

  always #5 clk = ~clk;

  ni_packet_tx #(.PHIT_WIDTH(PW), .PHIT_PER_FLIT(PPF), .FLIT_PER_PACKET(FPP),
                 .DEST_WIDTH(DW), .TYPE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pktValid), .pkt_ready(pktReady),
    .pkt_dest(pktDest), .pkt_payload(pktPayload), .phit_out(phitOut),
    .flit_type_out(flitType), .valid_out(validOut), .ready_out(readyOut),
    .pkt_done(pktDone));

  ni_packet_tx #(.PHIT_WIDTH(PW), .PHIT_PER_FLIT(PPF), .FLIT_PER_PACKET(2),
                 .DEST_WIDTH(DW), .TYPE_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .pkt_valid(pktValid1), .pkt_ready(pktReady1),
    .pkt_dest(pktDest1), .pkt_payload(pktPayload1), .phit_out(phitOut1),
    .flit_type_out(flitType1), .valid_out(validOut1), .ready_out(readyOut1),
    .pkt_done(pktDone1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: a packet is the list of phits it must produce, in order.
  function automatic void expandPkt(input int id, input logic [3:0] d, input logic [47:0] pay,
                                    input int fpp);
    exp_t e;
    for (int p = 0; p < PPF; p++) begin
      e.phit = (p == 0) ? {4'b0, d} : 8'h00;
      e.typ  = 2'd1;
      e.last = 1'b0;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int f = 1; f < fpp; f++) begin
      for (int p = 0; p < PPF; p++) begin
        e.phit = pay[((f-1)*PPF + p)*8 +: 8];
        e.typ  = (f == fpp - 1) ? 2'd3 : 2'd2;
        e.last = (f == fpp - 1) && (p == PPF - 1);
        if (id == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endfunction

  task automatic checkPort(input int id, input string nm, input logic valid, input logic [7:0] phit,
                           input logic [1:0] typ, input logic done, input logic rdy,
                           input logic rdyOut, input logic pv, input logic [3:0] d,
                           input logic [47:0] pay, input int fpp, output logic acc);
    int   sz;
    exp_t e;
    logic expRdy, expDone;
    sz = (id == 0) ? q0.size() : q1.size();
    e  = '0;
    if (sz > 0) e = (id == 0) ? q0[0] : q1[0];
    expRdy  = !rst && (sz == 0 || (B2B && sz == 1 && rdyOut));
    expDone = (sz > 0) && rdyOut && e.last;
    chk({nm, ".valid"}, 64'(valid), 64'(sz > 0));
    chk({nm, ".phit"}, 64'(phit), 64'(e.phit));
    chk({nm, ".type"}, 64'(typ), 64'(e.typ));
    chk({nm, ".done"}, 64'(done), 64'(expDone));
    chk({nm, ".pkt_ready"}, 64'(rdy), 64'(expRdy));
    acc = pv && expRdy;
    if (sz > 0 && rdyOut) begin
      if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (acc) expandPkt(id, d, pay, fpp);
    if (rst) begin
      if (id == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic cycle();
    logic a0, a1;
    #1;
    checkPort(0, "p4", validOut, phitOut, flitType, pktDone, pktReady, readyOut,
              pktValid, pktDest, pktPayload, FPP, a0);
    checkPort(1, "p2", validOut1, phitOut1, flitType1, pktDone1, pktReady1, readyOut1,
              pktValid1, pktDest1, {32'h0, pktPayload1}, 2, a1);
    sValid = validOut;
    sDone  = pktDone;
    sPhit  = phitOut;
    sType  = flitType;
    sAcc   = a0;
    sAcc1  = a1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nAcc, phase, gap;
    pktValid = 0; pktDest = '0; pktPayload = '0; readyOut = 1;
    pktValid1 = 0; pktDest1 = '0; pktPayload1 = '0; readyOut1 = 1;
    rst = 1;
    @(negedge clk);

    // Reset held for three cycles, then pkt_ready rises at once
    repeat (3) cycle();
    rst = 0;
    cycle();

    // Single packet with free-flowing output
    pktValid = 1; pktDest = 4'd5; pktPayload = 48'h665544332211;
    cycle();
    chk("single.accept", 64'(sAcc), 64'(1));
    pktValid = 0;
    repeat (8) cycle();
    chk("single.lastDone", 64'(sDone), 64'(1));
    chk("single.lastPhit", 64'(sPhit), 64'h66);
    cycle();

    // Backpressure while phit 33 is on the link
    pktValid = 1; pktDest = 4'd9; pktPayload = 48'h665544332211;
    cycle();
    pktValid = 0;
    repeat (4) cycle();
    readyOut = 0;
    repeat (3) cycle();
    chk("bp.holdPhit", 64'(sPhit), 64'h33);
    chk("bp.holdType", 64'(sType), 64'd2);
    chk("bp.holdValid", 64'(sValid), 64'd1);
    readyOut = 1;
    cycle();
    cycle();
    chk("bp.resume", 64'(sPhit), 64'h44);
    repeat (4) cycle();

    // Back-to-back packets with pkt_valid held
    pktValid = 1; pktDest = 4'd2; pktPayload = 48'hA6A5A4A3A2A1;
    nAcc = 0; phase = 0; gap = 0;
    for (int i = 0; i < 40 && phase < 2; i++) begin
      cycle();
      if (phase == 1) begin
        if (sValid) phase = 2; else gap++;
      end else if (phase == 0 && sDone) begin
        phase = 1;
      end
      if (sAcc) begin
        nAcc++;
        if (nAcc == 1) begin
          pktDest = 4'd7; pktPayload = 48'hB6B5B4B3B2B1;
        end else begin
          pktValid = 0;
        end
      end
    end
    chk("b2b.reached", 64'(phase), 64'd2);
    chk("b2b.gap", 64'(gap), B2B ? 64'd0 : 64'd1);
    chk("b2b.head2", 64'(sPhit), 64'h07);
    pktValid = 0;
    repeat (10) cycle();

    // Reset in the middle of a packet
    pktValid = 1; pktDest = 4'hC; pktPayload = 48'h0F0E0D0C0B0A;
    cycle();
    pktValid = 0;
    repeat (4) cycle();
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    chk("rstmid.valid", 64'(sValid), 64'd0);
    pktValid = 1; pktDest = 4'hA; pktPayload = 48'h1F1E1D1C1B1A;
    cycle();
    pktValid = 0;
    cycle();
    chk("rstmid.head", 64'(sPhit), 64'h0A);
    chk("rstmid.type", 64'(sType), 64'd1);
    repeat (8) cycle();

    // Two-flit packet: head then tail, no payload flit
    pktValid1 = 1; pktDest1 = 4'd3; pktPayload1 = 16'hBBAA;
    cycle();
    chk("fpp2.accept", 64'(sAcc1), 64'd1);
    pktValid1 = 0;
    repeat (5) cycle();

    // Randomized traffic and backpressure on both instances
    for (int i = 0; i < 400; i++) begin
      readyOut  = ($urandom_range(0, 3) != 0);
      readyOut1 = ($urandom_range(0, 3) != 0);
      if (!pktValid && $urandom_range(0, 2) == 0) begin
        pktValid = 1; pktDest = 4'($urandom); pktPayload = {16'($urandom), 32'($urandom)};
      end
      if (!pktValid1 && $urandom_range(0, 2) == 0) begin
        pktValid1 = 1; pktDest1 = 4'($urandom); pktPayload1 = 16'($urandom);
      end
      cycle();
      if (sAcc) begin
        pktValid = 1'($urandom_range(0, 1));
        pktDest = 4'($urandom); pktPayload = {16'($urandom), 32'($urandom)};
      end
      if (sAcc1) begin
        pktValid1 = 1'($urandom_range(0, 1));
        pktDest1 = 4'($urandom); pktPayload1 = 16'($urandom);
      end
    end
    pktValid = 0; pktValid1 = 0; readyOut = 1; readyOut1 = 1;
    repeat (20) cycle();
    chk("drain.p4", 64'(q0.size()), 64'd0);
    chk("drain.p2", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
